mem_access_ctrl: RTL and testbench

Sequential load/store controller between the datapath and `memory_unit`. It accepts one request at a time over a valid/ready handshake and drives the memory's enable, read/write, address, data and word-select lines, keeping them stable for a programmable number of cycles. For reads it captures the memory's big-endian result and returns it zero- or sign-extended to 32 bits. The memory's MFC pulse is zero-width, so completion is timed by an internal wait-state counter, not by MFC.

---
 rtl/mem_access_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential load/store controller in front of memory_unit.
// Accepts one request at a time, presents a stable address/data/word-select
// for one setup cycle plus WAIT_CYCLES enabled cycles, and returns load data
// extended to 32 bits. Completion is timed by a wait-state counter because
// the memory's MFC pulse is zero-width.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword,
// misaligned word and reserved-size requests with a one-cycle fault response.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_enable,
  output logic        mem_readwrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic [1:0]  mem_word_sel,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Counter reload: ACCESS lasts WAIT_CYCLES cycles, ending when the count hits 0.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 32'd1);

  // Right-aligned store data placed on the bus with unused upper bits cleared.
  function automatic logic [31:0] store_format(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] res;
    case (size)
      2'b10:   res = wdata;
      2'b01:   res = {16'h0000, wdata[15:0]};
      default: res = {24'h000000, wdata[7:0]};
    endcase
    return res;
  endfunction

  // Keep only the bits memory actually drove for this size; the rest are stale.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [31:0] raw);
    logic [31:0] res;
    case (size)
      2'b10:   res = raw;
      2'b01:   res = {{16{sgn & raw[15]}}, raw[15:0]};
      default: res = {{24{sgn & raw[7]}}, raw[7:0]};
    endcase
    return res;
  endfunction

`ifdef MEM_ALIGN_CHECK_EN
  // Alignment violations: odd halfword, non-word-aligned word, reserved size.
  function automatic logic align_fault(input logic [1:0] size, input logic [1:0] addr_lo);
    logic res;
    case (size)
      2'b01:   res = addr_lo[0];
      2'b10:   res = (addr_lo != 2'b00);
      2'b11:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction
`endif

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic        mem_enable_q, mem_enable_d;
  logic        mem_readwrite_q, mem_readwrite_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_datain_q, mem_datain_d;
  logic [1:0]  mem_word_sel_q, mem_word_sel_d;
  logic        busy_s;

  // Next-state, request latching, wait counting and load capture.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
`ifdef MEM_ALIGN_CHECK_EN
          if (align_fault(req_size, req_addr[1:0])) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_SETUP;
          end
`else
          state_d  = ST_SETUP;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = WAIT_LOAD;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rdata_d = write_q ? 32'h0000_0000 : load_extend(size_q, signed_q, mem_dataout);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, so every output is a flop.
  always_comb begin
    busy_s          = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    req_ready_d     = (state_d == ST_IDLE);
    rsp_valid_d     = (state_d == ST_RESP) || (state_d == ST_FAULT);
    rsp_fault_d     = (state_d == ST_FAULT);
    mem_enable_d    = (state_d == ST_ACCESS);
    mem_readwrite_d = busy_s ? ~write_d : 1'b0;
    mem_address_d   = busy_s ? addr_d : 32'h0000_0000;
    mem_datain_d    = busy_s ? store_format(size_d, wdata_d) : 32'h0000_0000;
    mem_word_sel_d  = busy_s ? size_d : 2'b00;
  end

  // State and output registers; reset drops mem_enable without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      write_q         <= 1'b0;
      size_q          <= 2'b00;
      signed_q        <= 1'b0;
      addr_q          <= 32'h0000_0000;
      wdata_q         <= 32'h0000_0000;
      cnt_q           <= 4'd0;
      rdata_q         <= 32'h0000_0000;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_fault_q     <= 1'b0;
      mem_enable_q    <= 1'b0;
      mem_readwrite_q <= 1'b0;
      mem_address_q   <= 32'h0000_0000;
      mem_datain_q    <= 32'h0000_0000;
      mem_word_sel_q  <= 2'b00;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      size_q          <= size_d;
      signed_q        <= signed_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      cnt_q           <= cnt_d;
      rdata_q         <= rdata_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_fault_q     <= rsp_fault_d;
      mem_enable_q    <= mem_enable_d;
      mem_readwrite_q <= mem_readwrite_d;
      mem_address_q   <= mem_address_d;
      mem_datain_q    <= mem_datain_d;
      mem_word_sel_q  <= mem_word_sel_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_fault     = rsp_fault_q;
  assign rsp_rdata     = rdata_q;
  assign mem_enable    = mem_enable_q;
  assign mem_readwrite = mem_readwrite_q;
  assign mem_address   = mem_address_q;
  assign mem_datain    = mem_datain_q;
  assign mem_word_sel  = mem_word_sel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a big-endian byte-array memory
// model whose undriven DataOut bits keep their previous (stale) value.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_enable;
  logic        mem_readwrite;
  logic [31:0] mem_address;
  logic [31:0] mem_datain;
  logic [1:0]  mem_word_sel;
  logic [31:0] mem_dataout;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .mem_enable(mem_enable), .mem_readwrite(mem_readwrite),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_word_sel(mem_word_sel),
    .mem_dataout(mem_dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model
  logic [7:0]  mem [0:255];
  logic [31:0] stale_q = 32'h0;
  logic [7:0]  a0, a1, a2, a3;
  assign a0 = mem_address[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;

  always_comb begin
    mem_dataout = stale_q;
    if (mem_enable && mem_readwrite) begin
      case (mem_word_sel)
        2'b10:   mem_dataout = {mem[a0], mem[a1], mem[a2], mem[a3]};
        2'b01:   mem_dataout = {stale_q[31:16], mem[a0], mem[a1]};
        default: mem_dataout = {stale_q[31:8], mem[a0]};
      endcase
    end
  end

  always @(posedge clk) begin
    stale_q <= mem_dataout;
    if (mem_enable && !mem_readwrite) begin
      case (mem_word_sel)
        2'b10: begin
          mem[a0] <= mem_datain[31:24]; mem[a1] <= mem_datain[23:16];
          mem[a2] <= mem_datain[15:8];  mem[a3] <= mem_datain[7:0];
        end
        2'b01: begin
          mem[a0] <= mem_datain[15:8]; mem[a1] <= mem_datain[7:0];
        end
        default: mem[a0] <= mem_datain[7:0];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; returns latency (cycles after accept edge) and enable-cycle count.
  task automatic do_acc(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat,
                        output int en, output logic [31:0] din, output logic [1:0] ws);
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; en = 0; rd = 32'h0; flt = 1'b0; din = 32'h0; ws = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_enable) begin
        if (en == 0) begin
          din = mem_datain;
          ws  = mem_word_sel;
        end
        en++;
      end
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        flt = rsp_fault;
        break;
      end
    end
  endtask

  logic [31:0] rd, din;
  logic        flt;
  logic [1:0]  ws;
  int          lat, en;
  int          n_acc, n_rsp, n_en;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    chk("rst_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_rspv",   {31'h0, rsp_valid},  32'h0);
    chk("rst_fault",  {31'h0, rsp_fault},  32'h0);
    chk("rst_rdata",  rsp_rdata,           32'h0);
    chk("rst_en",     {31'h0, mem_enable}, 32'h0);
    chk("rst_rw",     {31'h0, mem_readwrite}, 32'h0);
    chk("rst_addr",   mem_address,         32'h0);
    chk("rst_din",    mem_datain,          32'h0);
    chk("rst_ws",     {30'h0, mem_word_sel}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Word store then word load
    do_acc(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, flt, lat, en, din, ws);
    chk("sw_lat", lat, 32'd4);
    chk("sw_en", en, 32'd2);
    chk("sw_din", din, 32'hDEADBEEF);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_fault", {31'h0, flt}, 32'h0);
    do_acc(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, flt, lat, en, din, ws);
    chk("lw_lat", lat, 32'd4);
    chk("lw_en", en, 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    // Byte store over a preloaded word; stale upper bits must be masked
    do_acc(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA, rd, flt, lat, en, din, ws);
    do_acc(1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, rd, flt, lat, en, din, ws);
    chk("sb_din", din, 32'h00000080);
    chk("sb_ws", {30'h0, ws}, 32'h0);
    chk("sb_mem21", {24'h0, mem[8'h21]}, 32'hAA);
    do_acc(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, rd, flt, lat, en, din, ws);
    chk("lb_signed", rd, 32'hFFFFFF80);
    do_acc(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, flt, lat, en, din, ws);
    chk("lbu", rd, 32'h00000080);

    // Halfword store, halfword loads, word load of the same location
    do_acc(1'b1, 2'b10, 1'b0, 32'h30, 32'h5555AAAA, rd, flt, lat, en, din, ws);
    do_acc(1'b1, 2'b01, 1'b0, 32'h30, 32'hFFFF8001, rd, flt, lat, en, din, ws);
    chk("sh_din", din, 32'h00008001);
    chk("sh_ws", {30'h0, ws}, 32'h1);
    do_acc(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, rd, flt, lat, en, din, ws);
    chk("lh_signed", rd, 32'hFFFF8001);
    do_acc(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, rd, flt, lat, en, din, ws);
    chk("lhu", rd, 32'h00008001);
    do_acc(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, flt, lat, en, din, ws);
    chk("lw_30", rd, 32'h8001AAAA);

    // Misaligned halfword load at 0x31
    do_acc(1'b0, 2'b01, 1'b0, 32'h31, 32'h0, rd, flt, lat, en, din, ws);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_fault", {31'h0, flt}, 32'h1);
    chk("mis_lat", lat, 32'd1);
    chk("mis_en", en, 32'd0);
    chk("mis_rdata", rd, 32'h0);
`else
    chk("mis_fault", {31'h0, flt}, 32'h0);
    chk("mis_lat", lat, 32'd4);
    chk("mis_en", en, 32'd2);
    chk("mis_rdata", rd, 32'h000001AA);
`endif

    // Reset during ACCESS of a store
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_en_before", {31'h0, mem_enable}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en_now", {31'h0, mem_enable}, 32'h0);
    chk("abort_rspv", {31'h0, rsp_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) n_rsp++;
    end
    chk("abort_no_rsp", n_rsp, 32'd0);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);

    // req_valid held high: accepted only in IDLE, one response per accept
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; req_valid = 1'b1;
    n_acc = 0; n_rsp = 0; n_en = 0;
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready && req_valid) n_acc++;
      if (mem_enable) n_en++;
      if (rsp_valid) begin
        n_rsp++;
        chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
      end
    end
    req_valid = 1'b0;
    chk("hold_acc", n_acc, 32'd3);
    chk("hold_rsp", n_rsp, 32'd3);
    chk("hold_en", n_en, 32'd6);
    @(negedge clk);
    chk("hold_idle", {31'h0, req_ready}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
